incdec_rmw_sequencer: RTL and testbench

//  Multi-cycle read-modify-write controller for INC (HL) / DEC (HL). Reads a byte from the

---
 rtl/incdec_rmw_sequencer.sv | 147 ++++++++++++++
 tb/tb_incdec_rmw_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/incdec_rmw_sequencer.sv
// Read-modify-write sequencer for INC (HL) / DEC (HL) around an 8-bit incrementer.
// Optional bus-access timeout enabled by defining INCDEC_RMW_TIMEOUT_EN.
module incdec_rmw_sequencer #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_Clk,
  input  logic              i_Reset_n,
  input  logic              i_Start,
  input  logic              i_Decrement,
  input  logic [ADDR_W-1:0] i_Addr,
  input  logic [3:0]        i_F,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic              o_Mem_Rd,
  output logic              o_Mem_Wr,
  output logic [7:0]        o_Mem_WData,
  input  logic [7:0]        i_Mem_RData,
  input  logic              i_Mem_Ready,
  output logic [7:0]        o_Inc_A,
  output logic [3:0]        o_Inc_F,
  output logic              o_Inc_Decrement,
  input  logic [7:0]        i_Inc_A,
  input  logic [3:0]        i_Inc_F,
  output logic [3:0]        o_F,
  output logic              o_F_We,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_addr;
  logic              r_dec;
  logic [3:0]        r_f_in;
  logic [7:0]        r_a;
  logic [7:0]        r_wdata;
  logic [3:0]        r_f;
  logic              w_to;
  logic              w_bus;

  assign w_bus = (r_state == S_READ) || (r_state == S_WRITE);

`ifdef INCDEC_RMW_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_wait;
  logic          r_err;

  assign w_to = w_bus && !i_Mem_Ready &&
                (r_wait == TW'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every entry into a bus state.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_to;
      if ((w_next != r_state) &&
          ((w_next == S_READ) || (w_next == S_WRITE)))
        r_wait <= '0;
      else if (w_bus && !i_Mem_Ready)
        r_wait <= r_wait + 1'b1;
    end
  end

  assign o_Error = r_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_to    = 1'b0;
  assign o_Error = 1'b0;
`endif

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_Start) w_next = S_READ;
      S_READ: begin
        if (i_Mem_Ready) w_next = S_EXEC;
        else if (w_to)   w_next = S_IDLE;
      end
      S_EXEC:  w_next = S_WRITE;
      S_WRITE: begin
        if (i_Mem_Ready) w_next = S_DONE;
        else if (w_to)   w_next = S_IDLE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_addr  <= '0;
      r_dec   <= 1'b0;
      r_f_in  <= '0;
      r_a     <= '0;
      r_wdata <= '0;
      r_f     <= '0;
    end else begin
      if ((r_state == S_IDLE) && i_Start) begin
        r_addr <= i_Addr;
        r_dec  <= i_Decrement;
        r_f_in <= i_F;
      end
      if ((r_state == S_READ) && i_Mem_Ready)
        r_a <= i_Mem_RData;
      // Incrementer output has settled from r_a by the end of EXEC.
      if (r_state == S_EXEC) begin
        r_wdata <= i_Inc_A;
        r_f     <= i_Inc_F;
      end
    end
  end

  assign o_Mem_Addr      = r_addr;
  assign o_Mem_Rd        = (r_state == S_READ);
  assign o_Mem_Wr        = (r_state == S_WRITE);
  assign o_Mem_WData     = r_wdata;
  assign o_Inc_A         = r_a;
  assign o_Inc_F         = r_f_in;
  assign o_Inc_Decrement = r_dec;
  assign o_F             = r_f;
  assign o_F_We          = (r_state == S_DONE);
  assign o_Done          = (r_state == S_DONE);
  assign o_Busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_incdec_rmw_sequencer.sv
// Bench for incdec_rmw_sequencer: directed and random ops against an arithmetic model.
// Timeout scenario runs only when INCDEC_RMW_TIMEOUT_EN is defined.
module tb_incdec_rmw_sequencer;

  logic        clk;
  logic        i_Reset_n;
  logic        i_Start;
  logic        i_Decrement;
  logic [15:0] i_Addr;
  logic [3:0]  i_F;
  logic [15:0] o_Mem_Addr;
  logic        o_Mem_Rd;
  logic        o_Mem_Wr;
  logic [7:0]  o_Mem_WData;
  logic [7:0]  i_Mem_RData;
  logic        i_Mem_Ready;
  logic [7:0]  o_Inc_A;
  logic [3:0]  o_Inc_F;
  logic        o_Inc_Decrement;
  logic [7:0]  i_Inc_A;
  logic [3:0]  i_Inc_F;
  logic [3:0]  o_F;
  logic        o_F_We;
  logic        o_Busy;
  logic        o_Done;
  logic        o_Error;

  int checks   = 0;
  int failures = 0;

  incdec_rmw_sequencer #(
    .ADDR_W(16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_Clk(clk),
    .i_Reset_n(i_Reset_n),
    .i_Start(i_Start),
    .i_Decrement(i_Decrement),
    .i_Addr(i_Addr),
    .i_F(i_F),
    .o_Mem_Addr(o_Mem_Addr),
    .o_Mem_Rd(o_Mem_Rd),
    .o_Mem_Wr(o_Mem_Wr),
    .o_Mem_WData(o_Mem_WData),
    .i_Mem_RData(i_Mem_RData),
    .i_Mem_Ready(i_Mem_Ready),
    .o_Inc_A(o_Inc_A),
    .o_Inc_F(o_Inc_F),
    .o_Inc_Decrement(o_Inc_Decrement),
    .i_Inc_A(i_Inc_A),
    .i_Inc_F(i_Inc_F),
    .o_F(o_F),
    .o_F_We(o_F_We),
    .o_Busy(o_Busy),
    .o_Done(o_Done),
    .o_Error(o_Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream incrementer stand-in
  always_comb begin
    i_Inc_A = o_Inc_Decrement ? o_Inc_A - 8'd1 : o_Inc_A + 8'd1;
    i_Inc_F = {i_Inc_A == 8'd0, o_Inc_Decrement,
               o_Inc_Decrement ? (o_Inc_A[3:0] == 4'h0)
                               : (o_Inc_A[3:0] == 4'hF),
               o_Inc_F[0]};
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, {16'd0, o_Mem_Addr}, 32'd0);
    chk({tag, "_ctl"},
        {24'd0, o_Mem_Rd, o_Mem_Wr, o_F_We, o_Busy,
         o_Done, o_Error, o_Inc_Decrement, 1'b0}, 32'd0);
    chk({tag, "_data"},
        {4'd0, o_Mem_WData, o_Inc_A, o_Inc_F, o_F}, 32'd0);
  endtask

  task automatic run_op(input logic [15:0] addr, input logic dec,
                        input logic [7:0] a, input logic [3:0] f,
                        input int rw, input int ww,
                        input bit pulse, input bit rst_wr);
    int cyc, rcnt, wcnt, nrd, nwr;
    bit done;
    logic [7:0] er;
    logic [3:0] ef;
    er = 8'((int'(a) + (dec ? 255 : 1)) % 256);
    ef = {er == 8'd0, dec,
          dec ? (int'(a) % 16 == 0) : (int'(a) % 16 == 15), f[0]};
    rcnt = 0; wcnt = 0; nrd = 0; nwr = 0; done = 0;
    @(negedge clk);
    i_Start = 1'b1; i_Addr = addr; i_Decrement = dec; i_F = f;
    @(negedge clk);
    i_Addr = 16'($urandom); i_Decrement = ~dec; i_F = ~f;
    cyc = 1;
    while (!done && cyc < 100) begin
      i_Mem_Ready = 1'b0;
      i_Mem_RData = 8'($urandom);
      i_Start = pulse && (cyc == 2);
      if (o_Mem_Rd || o_Mem_Wr)
        chk("rd_wr_excl", {31'd0, o_Mem_Rd & o_Mem_Wr}, 32'd0);
      if (o_Mem_Rd) begin
        chk("rd_addr", {16'd0, o_Mem_Addr}, {16'd0, addr});
        if (rcnt < rw) rcnt++;
        else begin
          i_Mem_Ready = 1'b1; i_Mem_RData = a; nrd++;
        end
      end else if (o_Mem_Wr) begin
        chk("wr_addr", {16'd0, o_Mem_Addr}, {16'd0, addr});
        chk("wr_data", {24'd0, o_Mem_WData}, {24'd0, er});
        if (rst_wr) begin
          i_Reset_n = 1'b0;
          #1;
          chk_all_zero("rst_mid_write");
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_done", {30'd0, o_Done, o_F_We}, 32'd0);
          end
          i_Reset_n = 1'b1;
          i_Mem_Ready = 1'b0;
          i_Start = 1'b0;
          return;
        end
        if (wcnt < ww) wcnt++;
        else begin
          i_Mem_Ready = 1'b1; nwr++;
        end
      end else if (o_Done) begin
        chk("done_cycle", cyc, 4 + rw + ww);
        chk("f_we", {31'd0, o_F_We}, 32'd1);
        chk("flags", {28'd0, o_F}, {28'd0, ef});
        done = 1;
      end else if (o_Busy) begin
        chk("inc_a", {24'd0, o_Inc_A}, {24'd0, a});
        chk("inc_dir", {31'd0, o_Inc_Decrement}, {31'd0, dec});
        chk("inc_f", {28'd0, o_Inc_F}, {28'd0, f});
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("n_reads", nrd, 1);
    chk("n_writes", nwr, 1);
    i_Mem_Ready = 1'b0;
    i_Start = 1'b0;
    @(negedge clk);
    chk("idle_after", {29'd0, o_Busy, o_Done, o_Mem_Rd}, 32'd0);
  endtask

  initial begin
    i_Reset_n = 1'b0; i_Start = 1'b0; i_Decrement = 1'b0;
    i_Addr = 16'h0; i_F = 4'h0; i_Mem_RData = 8'h0; i_Mem_Ready = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    i_Reset_n = 1'b1;

    run_op(16'hC000, 1'b0, 8'h0F, 4'b0001, 0, 0, 1'b0, 1'b0);
    run_op(16'h1234, 1'b1, 8'h00, 4'b0000, 0, 0, 1'b0, 1'b0);
    run_op(16'h8001, 1'b0, 8'hFF, 4'b0000, 0, 0, 1'b0, 1'b0);
    run_op(16'h8002, 1'b1, 8'h01, 4'b0000, 0, 0, 1'b0, 1'b0);
    run_op(16'hBEEF, 1'b0, 8'h3A, 4'b1111, 3, 2, 1'b1, 1'b0);
    run_op(16'h4321, 1'b0, 8'h55, 4'b0001, 1, 3, 1'b0, 1'b1);
    run_op(16'h4321, 1'b1, 8'h10, 4'b1001, 0, 1, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++)
      run_op(16'($urandom), 1'($urandom), 8'($urandom), 4'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'($urandom), 1'b0);

`ifdef INCDEC_RMW_TIMEOUT_EN
    begin
      int cyc;
      bit wr_seen, we_seen, err_seen;
      wr_seen = 0; we_seen = 0; err_seen = 0;
      @(negedge clk);
      i_Start = 1'b1; i_Addr = 16'hA5A5; i_Decrement = 1'b0; i_F = 4'h0;
      @(negedge clk);
      i_Start = 1'b0;
      i_Mem_Ready = 1'b0;
      cyc = 1;
      while (!err_seen && cyc < 40) begin
        if (o_Mem_Wr) wr_seen = 1;
        if (o_F_We)   we_seen = 1;
        if (o_Error)  err_seen = 1;
        else begin
          @(negedge clk);
          cyc++;
        end
      end
      chk("to_error_seen", {31'd0, err_seen}, 32'd1);
      chk("to_error_cycle", cyc, 9);
      chk("to_busy_low", {31'd0, o_Busy}, 32'd0);
      chk("to_no_wr_we", {30'd0, wr_seen, we_seen}, 32'd0);
      @(negedge clk);
      chk("to_error_pulse", {31'd0, o_Error}, 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
